// File: rtl/mem_program_loader_pkg.sv
// Shared types and defaults for the boot-time program loader.
package mem_program_loader_pkg;

    localparam int MAX_WORDS_DEF = 1024;
    localparam int ADDR_W_DEF    = 16;

    typedef enum logic [2:0] {
        LD_LEN_HI,
        LD_LEN_LO,
        LD_DATA_HI,
        LD_DATA_LO,
        LD_CSUM,
        LD_DONE,
        LD_ERROR
    } loader_state_e;

    function automatic logic takes_bytes(loader_state_e s);
        return !(s == LD_DONE || s == LD_ERROR);
    endfunction

endpackage

// File: rtl/mem_program_loader_if.sv
// Byte-stream input, program-memory write port and core-reset status bundle.
interface mem_program_loader_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [15:0]       prog_wdata;
    logic              cpu_rst;
    logic              done;
    logic              error;

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, prog_we, prog_addr, prog_wdata,
        output cpu_rst, done, error
    );

    modport master (
        output start, in_valid, in_data,
        input  in_ready, prog_we, prog_addr, prog_wdata,
        input  cpu_rst, done, error
    );
endinterface

// File: rtl/mem_program_loader.sv
// Loads a length-prefixed, XOR-checksummed image of 16-bit words into
// program memory and holds the core in reset until the image is good.
module mem_program_loader
    import mem_program_loader_pkg::*;
#(
    parameter int MAX_WORDS = MAX_WORDS_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_program_loader_if.slave   bus
);

    localparam int IDX_W = $clog2(MAX_WORDS);

    loader_state_e     state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [7:0]        hi_q, hi_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [15:0]       rem_q, rem_d;
    logic [7:0]        csum_q, csum_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              cpu_rst_q, cpu_rst_d;

    logic        in_ready;
    logic        xfer;
    logic [15:0] len;

    assign in_ready = takes_bytes(state_q);
    assign xfer     = bus.in_valid & in_ready;
    assign len      = {len_hi_q, bus.in_data};

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        hi_d     = hi_q;
        idx_d    = idx_q;
        rem_d    = rem_q;
        csum_d   = csum_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        unique case (state_q)
            LD_LEN_HI: if (xfer) begin
                len_hi_d = bus.in_data;
                csum_d   = csum_q ^ bus.in_data;
                state_d  = LD_LEN_LO;
            end
            LD_LEN_LO: if (xfer) begin
                csum_d = csum_q ^ bus.in_data;
                rem_d  = len;
                if (len == 16'd0)
                    state_d = LD_CSUM;
                else if (int'(len) > MAX_WORDS)
                    state_d = LD_ERROR;
                else
                    state_d = LD_DATA_HI;
            end
            LD_DATA_HI: if (xfer) begin
                hi_d    = bus.in_data;
                csum_d  = csum_q ^ bus.in_data;
                state_d = LD_DATA_LO;
            end
            LD_DATA_LO: if (xfer) begin
                we_d    = 1'b1;
                wdata_d = {hi_q, bus.in_data};
                addr_d  = ADDR_W'({idx_q, 1'b0});
                csum_d  = csum_q ^ bus.in_data;
                rem_d   = rem_q - 16'd1;
                // Index stays on the last word so it never passes MAX_WORDS-1.
                if (rem_q == 16'd1) begin
                    state_d = LD_CSUM;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = LD_DATA_HI;
                end
            end
            LD_CSUM: if (xfer) begin
                state_d = (bus.in_data == csum_q) ? LD_DONE : LD_ERROR;
            end
            LD_DONE, LD_ERROR: if (bus.start) begin
                state_d  = LD_LEN_HI;
                len_hi_d = '0;
                idx_d    = '0;
                rem_d    = '0;
                csum_d   = '0;
            end
            default: state_d = LD_LEN_HI;
        endcase
        done_d    = (state_d == LD_DONE);
        error_d   = (state_d == LD_ERROR);
        cpu_rst_d = (state_d != LD_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= LD_LEN_HI;
            len_hi_q  <= '0;
            hi_q      <= '0;
            idx_q     <= '0;
            rem_q     <= '0;
            csum_q    <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            len_hi_q  <= len_hi_d;
            hi_q      <= hi_d;
            idx_q     <= idx_d;
            rem_q     <= rem_d;
            csum_q    <= csum_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            done_q    <= done_d;
            error_q   <= error_d;
            cpu_rst_q <= cpu_rst_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.prog_we    = we_q;
    assign bus.prog_addr  = addr_q;
    assign bus.prog_wdata = wdata_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.cpu_rst    = cpu_rst_q;

endmodule
